// File: rtl/usb_rx_pkt_ctrl.sv
// Packet sequencer behind the USB RX control unit: checks the PID byte, steers payload
// bytes into the RX FIFO, enforces the length limit and reports completion / error cause.
module usb_rx_pkt_ctrl #(
    parameter int MAX_BYTES = 64,
    localparam int CW = $clog2(MAX_BYTES + 1)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          rcving,
    input  logic          w_enable,
    input  logic          r_error,
    input  logic [7:0]    rcv_data,
    input  logic          fifo_full,
    output logic          fifo_wr,
    output logic [7:0]    fifo_wdata,
    output logic          fifo_clr,
    output logic [3:0]    pid,
    output logic          pid_valid,
    output logic [CW-1:0] byte_count,
    output logic          pkt_done,
    output logic [2:0]    pkt_err,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PID_WAIT = 3'd1,
        DATA     = 3'd2,
        DONE     = 3'd3,
        ERR      = 3'd4
    } state_t;

    localparam logic [2:0] ERR_LINE     = 3'd1;
    localparam logic [2:0] ERR_PID      = 3'd2;
    localparam logic [2:0] ERR_SHORT    = 3'd3;
    localparam logic [2:0] ERR_OVERFLOW = 3'd4;
    localparam logic [2:0] ERR_LENGTH   = 3'd5;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES);

    state_t        state_reg, state_next;
    logic          rcving_q;
    logic          rise_pend_reg, rise_pend_next;
    logic          fifo_wr_reg, fifo_wr_next;
    logic [7:0]    fifo_wdata_reg, fifo_wdata_next;
    logic          fifo_clr_reg, fifo_clr_next;
    logic [3:0]    pid_reg, pid_next;
    logic          pid_valid_reg, pid_valid_next;
    logic [CW-1:0] byte_count_reg, byte_count_next;
    logic          pkt_done_reg, pkt_done_next;
    logic [2:0]    pkt_err_reg, pkt_err_next;
    logic          busy_reg, busy_next;

    logic          rcv_rise;
    logic          rcv_fall;
    logic          pid_ok;
    logic          enter_err;
    logic [2:0]    err_code;

    assign rcv_rise = rcving & ~rcving_q;
    assign rcv_fall = rcving_q & ~rcving;
    assign pid_ok   = (rcv_data[7:4] == ~rcv_data[3:0]);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            // Track the live line so a packet in flight at release is not seen as a new rise.
            rcving_q       <= rcving;
            rise_pend_reg  <= 1'b0;
            fifo_wr_reg    <= 1'b0;
            fifo_wdata_reg <= '0;
            fifo_clr_reg   <= 1'b0;
            pid_reg        <= '0;
            pid_valid_reg  <= 1'b0;
            byte_count_reg <= '0;
            pkt_done_reg   <= 1'b0;
            pkt_err_reg    <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rcving_q       <= rcving;
            rise_pend_reg  <= rise_pend_next;
            fifo_wr_reg    <= fifo_wr_next;
            fifo_wdata_reg <= fifo_wdata_next;
            fifo_clr_reg   <= fifo_clr_next;
            pid_reg        <= pid_next;
            pid_valid_reg  <= pid_valid_next;
            byte_count_reg <= byte_count_next;
            pkt_done_reg   <= pkt_done_next;
            pkt_err_reg    <= pkt_err_next;
            busy_reg       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rise_pend_next  = rise_pend_reg;
        fifo_wr_next    = 1'b0;
        fifo_wdata_next = fifo_wdata_reg;
        fifo_clr_next   = 1'b0;
        pid_next        = pid_reg;
        pid_valid_next  = pid_valid_reg;
        byte_count_next = byte_count_reg;
        pkt_done_next   = 1'b0;
        pkt_err_next    = pkt_err_reg;
        enter_err       = 1'b0;
        err_code        = '0;

        case (state_reg)
            IDLE: begin
                if (rcv_rise || rise_pend_reg) begin
                    state_next      = PID_WAIT;
                    rise_pend_next  = 1'b0;
                    pid_next        = '0;
                    pid_valid_next  = 1'b0;
                    byte_count_next = '0;
                    pkt_err_next    = '0;
                    fifo_clr_next   = 1'b1;
                end
            end

            PID_WAIT: begin
                if (r_error) begin
                    enter_err = 1'b1;
                    err_code  = ERR_LINE;
                end else if (w_enable) begin
                    if (pid_ok) begin
                        pid_next       = rcv_data[3:0];
                        pid_valid_next = 1'b1;
                        // A PID-only packet that ends on the PID strobe is still complete.
                        if (rcv_fall) begin
                            state_next    = DONE;
                            pkt_done_next = 1'b1;
                        end else begin
                            state_next = DATA;
                        end
                    end else begin
                        enter_err = 1'b1;
                        err_code  = ERR_PID;
                    end
                end else if (rcv_fall) begin
                    enter_err = 1'b1;
                    err_code  = ERR_SHORT;
                end
            end

            DATA: begin
                if (r_error) begin
                    enter_err = 1'b1;
                    err_code  = ERR_LINE;
                end else if (w_enable) begin
                    if (byte_count_reg == MAX_CNT) begin
                        enter_err = 1'b1;
                        err_code  = ERR_LENGTH;
                    end else if (fifo_full) begin
                        enter_err = 1'b1;
                        err_code  = ERR_OVERFLOW;
                    end else begin
                        fifo_wr_next    = 1'b1;
                        fifo_wdata_next = rcv_data;
                        byte_count_next = byte_count_reg + 1'b1;
                        if (rcv_fall) begin
                            state_next    = DONE;
                            pkt_done_next = 1'b1;
                        end
                    end
                end else if (rcv_fall) begin
                    state_next    = DONE;
                    pkt_done_next = 1'b1;
                end
            end

            DONE: begin
                state_next = IDLE;
                if (rcv_rise) rise_pend_next = 1'b1;
            end

            ERR: begin
                if (!rcving) begin
                    state_next    = IDLE;
                    pkt_done_next = 1'b1;
                end else if (rcv_rise) begin
                    rise_pend_next = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        if (enter_err) begin
            state_next     = ERR;
            pkt_err_next   = err_code;
            fifo_clr_next  = 1'b1;
            pid_valid_next = 1'b0;
        end
    end

    assign busy_next = (state_next != IDLE);

    assign fifo_wr    = fifo_wr_reg;
    assign fifo_wdata = fifo_wdata_reg;
    assign fifo_clr   = fifo_clr_reg;
    assign pid        = pid_reg;
    assign pid_valid  = pid_valid_reg;
    assign byte_count = byte_count_reg;
    assign pkt_done   = pkt_done_reg;
    assign pkt_err    = pkt_err_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_usb_rx_pkt_ctrl.sv
// Directed bench for usb_rx_pkt_ctrl with a 4-byte payload limit; one line per packet check.
module tb_usb_rx_pkt_ctrl;

    localparam int MAX_BYTES = 4;
    localparam int CW = $clog2(MAX_BYTES + 1);

    logic          clk = 1'b0;
    logic          n_rst;
    logic          rcving;
    logic          w_enable;
    logic          r_error;
    logic [7:0]    rcv_data;
    logic          fifo_full;
    logic          fifo_wr;
    logic [7:0]    fifo_wdata;
    logic          fifo_clr;
    logic [3:0]    pid;
    logic          pid_valid;
    logic [CW-1:0] byte_count;
    logic          pkt_done;
    logic [2:0]    pkt_err;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         clr_cnt  = 0;
    logic [7:0] wr_log [0:63];

    int wr_base, done_base, clr_base;

    usb_rx_pkt_ctrl #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .rcving     (rcving),
        .w_enable   (w_enable),
        .r_error    (r_error),
        .rcv_data   (rcv_data),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_clr   (fifo_clr),
        .pid        (pid),
        .pid_valid  (pid_valid),
        .byte_count (byte_count),
        .pkt_done   (pkt_done),
        .pkt_err    (pkt_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (fifo_wr === 1'b1) begin
            wr_log[wr_cnt[5:0]] <= fifo_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (pkt_done === 1'b1) done_cnt <= done_cnt + 1;
        if (fifo_clr === 1'b1) clr_cnt <= clr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        wr_base   = wr_cnt;
        done_base = done_cnt;
        clr_base  = clr_cnt;
    endtask

    task automatic send_byte(input logic [7:0] d);
        w_enable = 1'b1;
        rcv_data = d;
        tick();
        w_enable = 1'b0;
        rcv_data = 8'h00;
        tick();
    endtask

    task automatic start_pkt();
        rcving = 1'b1;
        tick(2);
    endtask

    task automatic end_pkt();
        rcving = 1'b0;
        tick(3);
    endtask

    initial begin
        n_rst     = 1'b0;
        rcving    = 1'b0;
        w_enable  = 1'b0;
        r_error   = 1'b0;
        rcv_data  = 8'h00;
        fifo_full = 1'b0;
        tick(2);
        check("rst_busy",      busy,       0);
        check("rst_pid",       pid,        0);
        check("rst_pid_valid", pid_valid,  0);
        check("rst_count",     byte_count, 0);
        check("rst_err",       pkt_err,    0);
        check("rst_done",      pkt_done,   0);
        check("rst_wr",        fifo_wr,    0);
        check("rst_clr",       fifo_clr,   0);
        n_rst = 1'b1;
        tick();

        // 1: good packet
        snap();
        start_pkt();
        check("t1_busy", busy, 1);
        send_byte(8'hC3);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        end_pkt();
        check("t1_pid",       pid,                 3);
        check("t1_pid_valid", pid_valid,           1);
        check("t1_count",     byte_count,          3);
        check("t1_err",       pkt_err,             0);
        check("t1_wr_n",      wr_cnt - wr_base,    3);
        check("t1_wd0",       wr_log[wr_base],     8'h11);
        check("t1_wd1",       wr_log[wr_base + 1], 8'h22);
        check("t1_wd2",       wr_log[wr_base + 2], 8'h33);
        check("t1_done_n",    done_cnt - done_base, 1);
        check("t1_clr_n",     clr_cnt - clr_base,   1);
        check("t1_idle",      busy,                0);
        $display("[TB] pkt1 good: pid=%0d count=%0d err=%0d", pid, byte_count, pkt_err);

        // 2: bad PID
        snap();
        start_pkt();
        send_byte(8'hC4);
        tick(2);
        check("t2_busy_err",  busy,                 1);
        check("t2_no_done",   done_cnt - done_base, 0);
        end_pkt();
        check("t2_err",       pkt_err,              2);
        check("t2_pid_valid", pid_valid,            0);
        check("t2_wr_n",      wr_cnt - wr_base,     0);
        check("t2_clr_n",     clr_cnt - clr_base,   2);
        check("t2_done_n",    done_cnt - done_base, 1);
        $display("[TB] pkt2 bad pid: err=%0d", pkt_err);

        // 3: line error after two payload bytes
        snap();
        start_pkt();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h02);
        r_error = 1'b1;
        tick();
        r_error = 1'b0;
        send_byte(8'h03);
        check("t3_no_done", done_cnt - done_base, 0);
        end_pkt();
        check("t3_err",    pkt_err,              1);
        check("t3_wr_n",   wr_cnt - wr_base,     2);
        check("t3_clr_n",  clr_cnt - clr_base,   2);
        check("t3_done_n", done_cnt - done_base, 1);
        check("t3_count",  byte_count,           2);
        $display("[TB] pkt3 line error: err=%0d writes=%0d", pkt_err, wr_cnt - wr_base);

        // 4: FIFO full on second payload byte
        snap();
        start_pkt();
        send_byte(8'hD2);
        send_byte(8'h44);
        fifo_full = 1'b1;
        send_byte(8'h55);
        fifo_full = 1'b0;
        end_pkt();
        check("t4_err",    pkt_err,              4);
        check("t4_count",  byte_count,           1);
        check("t4_wr_n",   wr_cnt - wr_base,     1);
        check("t4_wd0",    wr_log[wr_base],      8'h44);
        check("t4_done_n", done_cnt - done_base, 1);
        $display("[TB] pkt4 overflow: err=%0d count=%0d", pkt_err, byte_count);

        // 5a: payload one byte over the limit
        snap();
        start_pkt();
        send_byte(8'h96);
        for (int i = 0; i < 5; i++) send_byte(8'hA0 + 8'(i));
        end_pkt();
        check("t5_err",    pkt_err,              5);
        check("t5_count",  byte_count,           4);
        check("t5_wr_n",   wr_cnt - wr_base,     4);
        check("t5_wd3",    wr_log[wr_base + 3],  8'hA3);
        check("t5_done_n", done_cnt - done_base, 1);
        $display("[TB] pkt5 length: err=%0d count=%0d", pkt_err, byte_count);

        // 5b: PID-only packet
        snap();
        start_pkt();
        send_byte(8'hE1);
        end_pkt();
        check("t5b_err",       pkt_err,              0);
        check("t5b_count",     byte_count,           0);
        check("t5b_pid",       pid,                  1);
        check("t5b_pid_valid", pid_valid,            1);
        check("t5b_done_n",    done_cnt - done_base, 1);
        $display("[TB] pkt5b pid only: err=%0d count=%0d", pkt_err, byte_count);

        // 6a: reset mid-DATA, packet still in flight at release
        snap();
        start_pkt();
        send_byte(8'hB4);
        send_byte(8'h10);
        send_byte(8'h20);
        n_rst = 1'b0;
        tick();
        check("t6_busy",      busy,       0);
        check("t6_pid",       pid,        0);
        check("t6_pid_valid", pid_valid,  0);
        check("t6_count",     byte_count, 0);
        check("t6_err",       pkt_err,    0);
        n_rst = 1'b1;
        tick(3);
        check("t6_not_picked", busy, 0);
        end_pkt();
        check("t6_no_done", done_cnt - done_base, 0);
        $display("[TB] pkt6 reset mid-packet: done=%0d", done_cnt - done_base);

        // 6b: next rcving rise lands in the pkt_done cycle
        snap();
        start_pkt();
        send_byte(8'h87);
        send_byte(8'h5A);
        rcving = 1'b0;
        tick();
        check("t6b_done_pulse", pkt_done, 1);
        rcving = 1'b1;
        tick(3);
        check("t6b_busy", busy, 1);
        send_byte(8'h78);
        send_byte(8'h66);
        end_pkt();
        check("t6b_pid",    pid,                  8);
        check("t6b_count",  byte_count,           1);
        check("t6b_err",    pkt_err,              0);
        check("t6b_wr_n",   wr_cnt - wr_base,     2);
        check("t6b_wd1",    wr_log[wr_base + 1],  8'h66);
        check("t6b_done_n", done_cnt - done_base, 2);
        $display("[TB] pkt6b back-to-back: pid=%0d count=%0d", pid, byte_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
